knn_vote: RTL and testbench



---
 rtl/knn_vote.sv | 159 +++++++++++++++
 tb/tb_knn_vote.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/knn_vote.sv
// knn_vote: majority vote over a captured K-entry sorted neighbour list, one entry then one class per cycle.
// Optional build macro KNN_VOTE_TIEBREAK_EN: equal counts are resolved by the closest first neighbour.
module knn_vote #(
   parameter int K         = 4,
   parameter int DATA_W    = 32,
   parameter int LABEL_W   = 8,
   parameter int N_CLASS   = 10,
   parameter int DATA_INFO = DATA_W + LABEL_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [K*DATA_INFO-1:0]     nb_list,
   output logic                       busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [LABEL_W-1:0]         class_out,
   output logic [$clog2(K+1)-1:0]     votes,
   output logic [$clog2(K+1)-1:0]     skipped
);

   localparam int CNT_W = $clog2(K+1);
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
   localparam int CLS_W = (N_CLASS > 1) ? $clog2(N_CLASS) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, SCAN, DONE} state_t;

   state_t                 state;
   logic [IDX_W-1:0]       idx;
   logic [CLS_W-1:0]       c;
   logic [CNT_W-1:0]       skip_cnt;
   logic [CNT_W-1:0]       best_cnt;
   logic [LABEL_W-1:0]     best_cls;
   logic [K*DATA_INFO-1:0] list_q;
   logic [CNT_W-1:0]       cnt [N_CLASS];
`ifdef KNN_VOTE_TIEBREAK_EN
   logic [IDX_W-1:0]       rank [N_CLASS];
   logic [IDX_W-1:0]       best_rank;
`endif

   logic [DATA_INFO-1:0]   entry;
   logic [DATA_W-1:0]      entry_dist;
   logic [LABEL_W-1:0]     entry_lbl;
   logic [CLS_W-1:0]       entry_cls;
   logic                   entry_ok;
   logic [CNT_W-1:0]       cnt_c;
   logic                   take;

   assign entry      = list_q[idx*DATA_INFO +: DATA_INFO];
   assign entry_dist = entry[DATA_INFO-1:LABEL_W];
   assign entry_lbl  = entry[LABEL_W-1:0];
   assign entry_cls  = entry_lbl[CLS_W-1:0];
   assign entry_ok   = (entry_dist != '1) && (entry_lbl < LABEL_W'(N_CLASS));
   assign cnt_c      = cnt[c];

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      take = 1'b0;
      if (cnt_c > best_cnt)
         take = 1'b1;
`ifdef KNN_VOTE_TIEBREAK_EN
      else if ((cnt_c == best_cnt) && (cnt_c != '0) && (rank[c] < best_rank))
         take = 1'b1;
`endif
   end

   // NOTE: the captured list and class counters have no reset; they are always rewritten at capture before being read.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         list_q <= nb_list;
         for (int i = 0; i < N_CLASS; i++) begin
            cnt[i] <= '0;
`ifdef KNN_VOTE_TIEBREAK_EN
            rank[i] <= '1;
`endif
         end
      end else if (state == COUNT && entry_ok) begin
         cnt[entry_cls] <= cnt[entry_cls] + CNT_W'(1);
`ifdef KNN_VOTE_TIEBREAK_EN
         if (cnt[entry_cls] == '0)
            rank[entry_cls] <= idx;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         idx       <= '0;
         c         <= '0;
         skip_cnt  <= '0;
         best_cnt  <= '0;
         best_cls  <= '1;
`ifdef KNN_VOTE_TIEBREAK_EN
         best_rank <= '1;
`endif
         busy      <= 1'b0;
         out_valid <= 1'b0;
         class_out <= '1;
         votes     <= '0;
         skipped   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= COUNT;
                  idx       <= '0;
                  skip_cnt  <= '0;
                  best_cnt  <= '0;
                  best_cls  <= '1;
`ifdef KNN_VOTE_TIEBREAK_EN
                  best_rank <= '1;
`endif
                  busy      <= 1'b1;
               end
            end
            COUNT: begin
               if (!entry_ok)
                  skip_cnt <= skip_cnt + CNT_W'(1);
               if (idx == IDX_W'(K-1)) begin
                  state <= SCAN;
                  c     <= '0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            SCAN: begin
               if (take) begin
                  best_cnt  <= cnt_c;
                  best_cls  <= LABEL_W'(c);
`ifdef KNN_VOTE_TIEBREAK_EN
                  best_rank <= rank[c];
`endif
               end
               if (c == CLS_W'(N_CLASS-1))
                  state <= DONE;
               else
                  c <= c + CLS_W'(1);
            end
            DONE: begin
               // First DONE cycle registers the result; outputs then hold until the transfer.
               if (!out_valid) begin
                  out_valid <= 1'b1;
                  class_out <= best_cls;
                  votes     <= best_cnt;
                  skipped   <= skip_cnt;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed scoreboard bench for knn_vote; honours KNN_VOTE_TIEBREAK_EN for the tie case.
module tb_knn_vote;

   localparam int K         = 4;
   localparam int DATA_W    = 32;
   localparam int LABEL_W   = 8;
   localparam int N_CLASS   = 10;
   localparam int DATA_INFO = DATA_W + LABEL_W;
   localparam int NB_W      = K * DATA_INFO;
   localparam int CNT_W     = $clog2(K+1);
   localparam int LAT       = K + N_CLASS + 1;

`ifdef KNN_VOTE_TIEBREAK_EN
   localparam logic [7:0] TIE_CLS = 8'd5;
`else
   localparam logic [7:0] TIE_CLS = 8'd2;
`endif

   typedef logic [LABEL_W-1:0] lbl_a_t [K];
   typedef logic [DATA_W-1:0]  dist_a_t [K];
   typedef struct {
      logic [LABEL_W-1:0] cls;
      logic [CNT_W-1:0]   votes;
      logic [CNT_W-1:0]   skipped;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic               out_ready = 1'b0;
   logic [NB_W-1:0]    nb_list = '0;
   logic               busy;
   logic               out_valid;
   logic [LABEL_W-1:0] class_out;
   logic [CNT_W-1:0]   votes;
   logic [CNT_W-1:0]   skipped;

   exp_t q[$];
   int   passed = 0;
   int   total  = 0;

   knn_vote #(.K(K), .DATA_W(DATA_W), .LABEL_W(LABEL_W), .N_CLASS(N_CLASS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .nb_list   (nb_list),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .class_out (class_out),
      .votes     (votes),
      .skipped   (skipped)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [NB_W-1:0] pack(input lbl_a_t l, input dist_a_t d);
      logic [NB_W-1:0] r;
      r = '0;
      for (int i = 0; i < K; i++)
         r[i*DATA_INFO +: DATA_INFO] = {d[i], l[i]};
      return r;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic do_capture(input logic [NB_W-1:0] list);
      @(negedge clk);
      nb_list = list;
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Captures a list, optionally scrambles nb_list afterwards, waits for the result and scores it.
   task automatic vote(input string tag, input lbl_a_t l, input dist_a_t d, input exp_t e,
                       input logic scramble);
      exp_t got;
      int   lat;
      q.push_back(e);
      do_capture(pack(l, d));
      check({tag, "_busy"}, busy, 1);
      if (scramble)
         nb_list = ~nb_list;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 4*LAT) begin
         @(posedge clk);
         #1 lat++;
      end
      check({tag, "_latency"}, lat, LAT);
      check({tag, "_queue"}, q.size(), 1);
      if (q.size() != 0) begin
         got = q.pop_front();
         check({tag, "_class"}, class_out, got.cls);
         check({tag, "_votes"}, votes, got.votes);
         check({tag, "_skipped"}, skipped, got.skipped);
      end
   endtask

   task automatic finish_xfer(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_valid_drop"}, out_valid, 0);
      check({tag, "_busy_drop"}, busy, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_valid", out_valid, 0);
      check("rst_class", class_out, 8'hFF);
      check("rst_votes", votes, 0);
      check("rst_skipped", skipped, 0);
      rst = 1'b1;

      out_ready = 1'b1;
      vote("basic", '{8'd3, 8'd5, 8'd3, 8'd7}, '{32'd10, 32'd20, 32'd30, 32'd40},
           '{8'd3, 3'd2, 3'd0}, 1'b1);
      finish_xfer("basic");

      vote("tie", '{8'd5, 8'd2, 8'd2, 8'd5}, '{32'd1, 32'd2, 32'd3, 32'd4},
           '{TIE_CLS, 3'd2, 3'd0}, 1'b0);
      finish_xfer("tie");

      vote("none", '{8'd1, 8'd2, 8'd3, 8'd4}, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
           '{8'hFF, 3'd0, 3'd4}, 1'b0);
      finish_xfer("none");

      vote("range", '{8'd12, 8'd4, 8'd4, 8'd9}, '{32'd5, 32'd6, 32'd7, 32'd8},
           '{8'd4, 3'd2, 3'd1}, 1'b0);
      finish_xfer("range");

      // Backpressure: result holds while start pulses and nb_list changes.
      out_ready = 1'b0;
      vote("bp", '{8'd6, 8'd6, 8'd1, 8'd6}, '{32'd3, 32'd1, 32'd4, 32'd1},
           '{8'd6, 3'd3, 3'd0}, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = (i == 2);
         if (i == 2)
            nb_list = pack('{8'd1, 8'd1, 8'd1, 8'd1}, '{32'd0, 32'd0, 32'd0, 32'd0});
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_class", class_out, 8'd6);
         check("bp_hold_votes", votes, 3);
      end
      // start coincident with the handshake must be ignored.
      @(negedge clk);
      start     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("bp_xfer_valid", out_valid, 0);
      check("bp_xfer_busy", busy, 0);
      repeat (4) @(posedge clk);
      #1;
      check("bp_no_restart_busy", busy, 0);
      check("bp_no_restart_valid", out_valid, 0);

      // Reset during COUNT aborts; the next vote is clean.
      do_capture(pack('{8'd2, 8'd2, 8'd2, 8'd2}, '{32'd1, 32'd1, 32'd1, 32'd1}));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_valid", out_valid, 0);
      @(negedge clk);
      rst = 1'b1;
      vote("post_rst", '{8'd8, 8'd8, 8'd8, 8'd0}, '{32'd9, 32'd9, 32'd9, 32'd9},
           '{8'd8, 3'd3, 3'd0}, 1'b0);
      finish_xfer("post_rst");

      check("scoreboard_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
